// File: rtl/matrix_pixel_fetch.sv
// rtl/matrix_pixel_fetch.sv - pipelined multi-channel pixel fetch from framebuffer RAM
//
// Purpose: on an accepted start, issues one framebuffer read per display
// channel on consecutive cycles, captures each returned word after the RAM
// read latency into a shadow register, then publishes every channel pixel
// at once on the pixels bus together with a one-cycle valid strobe.
//
// Ports:
//   clk_in         - sole clock, rising edge
//   reset          - synchronous, active-high
//   start          - fetch request, honoured only while not busy
//   row_address    - row to fetch, sampled with an accepted start
//   column_address - column to fetch, sampled with an accepted start
//   ram_addr       - framebuffer read address {channel, row, column'}
//   ram_clk_en     - framebuffer read clock enable (equal to busy)
//   ram_data       - framebuffer read data
//   pixels         - channel k at [k*PIXEL_WIDTH +: PIXEL_WIDTH]
//   valid          - one-cycle strobe, pixels just updated
//   busy           - fetch in progress
//   overrun        - sticky, start arrived while busy
module matrix_pixel_fetch #(
   parameter int CHAN_BITS      = 1,
   parameter int ROW_BITS       = 4,
   parameter int COL_BITS       = 6,
   parameter int PIXEL_WIDTH    = 16,
   parameter int RAM_LATENCY    = 2,
   parameter int COLUMN_REVERSE = 1,
   localparam int CHANNELS      = 2 ** CHAN_BITS,
   localparam int ADDR_WIDTH    = CHAN_BITS + ROW_BITS + COL_BITS
) (
   input  logic                            clk_in,
   input  logic                            reset,
   input  logic                            start,
   input  logic [ROW_BITS-1:0]             row_address,
   input  logic [COL_BITS-1:0]             column_address,
   output logic [ADDR_WIDTH-1:0]           ram_addr,
   output logic                            ram_clk_en,
   input  logic [PIXEL_WIDTH-1:0]          ram_data,
   output logic [CHANNELS*PIXEL_WIDTH-1:0] pixels,
   output logic                            valid,
   output logic                            busy,
   output logic                            overrun
);

   // Channel counters keep at least one bit so CHAN_BITS=0 still elaborates.
   localparam int CW  = (CHAN_BITS > 0) ? CHAN_BITS : 1;
   localparam int RCW = ROW_BITS + COL_BITS;
   localparam int FW  = $clog2(CHANNELS + RAM_LATENCY + 1);

   localparam logic [CW-1:0] LAST_CHAN = CW'(CHANNELS - 1);
   // fetch_cnt counts FETCH cycles from 0; channel k is presented when it
   // equals k and its data is on ram_data when it equals k+RAM_LATENCY.
   localparam logic [FW-1:0] CAP_FIRST = FW'(RAM_LATENCY);
   localparam logic [FW-1:0] CAP_LAST  = FW'(CHANNELS - 1 + RAM_LATENCY);

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t                          state_q, state_d;
   logic [RCW-1:0]                  rc_q, rc_d;
   logic [CW-1:0]                   issue_q, issue_d;
   logic [CW-1:0]                   cap_q, cap_d;
   logic [FW-1:0]                   fetch_cnt_q, fetch_cnt_d;
   logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
   logic [CHANNELS*PIXEL_WIDTH-1:0] shadow_q, shadow_d;
   logic [CHANNELS*PIXEL_WIDTH-1:0] pixels_q, pixels_d;
   logic                            valid_q, valid_d;
   logic                            overrun_q, overrun_d;
   logic [COL_BITS-1:0]             col_eff;

   assign col_eff = (COLUMN_REVERSE != 0) ? ~column_address : column_address;

   // With no channel field the shifted term is entirely shifted out.
   function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [CW-1:0]  chan,
                                                       input logic [RCW-1:0] rc);
      make_addr = (ADDR_WIDTH'(chan) << RCW) | ADDR_WIDTH'(rc);
   endfunction

   always_comb begin
      state_d     = state_q;
      rc_d        = rc_q;
      issue_d     = issue_q;
      cap_d       = cap_q;
      fetch_cnt_d = fetch_cnt_q;
      addr_d      = addr_q;
      shadow_d    = shadow_q;
      pixels_d    = pixels_q;
      valid_d     = 1'b0;
      overrun_d   = overrun_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               rc_d        = {row_address, col_eff};
               issue_d     = '0;
               cap_d       = '0;
               fetch_cnt_d = '0;
               addr_d      = make_addr('0, {row_address, col_eff});
               state_d     = FETCH;
            end
         end
         FETCH: begin
            if (start) begin
               overrun_d = 1'b1;
            end
            fetch_cnt_d = fetch_cnt_q + 1'b1;
            // Issue side: one new channel address per cycle, then hold.
            if (issue_q != LAST_CHAN) begin
               issue_d = issue_q + 1'b1;
               addr_d  = make_addr(issue_q + 1'b1, rc_q);
            end
            // Capture side trails the issue side by RAM_LATENCY cycles.
            if (fetch_cnt_q >= CAP_FIRST) begin
               for (int k = 0; k < CHANNELS; k++) begin
                  if (cap_q == CW'(k)) begin
                     shadow_d[k*PIXEL_WIDTH +: PIXEL_WIDTH] = ram_data;
                  end
               end
               cap_d = cap_q + 1'b1;
            end
            // Publish from shadow_d so the final word lands in the same edge
            // as the rest of the set.
            if (fetch_cnt_q == CAP_LAST) begin
               pixels_d = shadow_d;
               valid_d  = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q     <= IDLE;
         rc_q        <= '0;
         issue_q     <= '0;
         cap_q       <= '0;
         fetch_cnt_q <= '0;
         addr_q      <= '0;
         shadow_q    <= '0;
         pixels_q    <= '0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rc_q        <= rc_d;
         issue_q     <= issue_d;
         cap_q       <= cap_d;
         fetch_cnt_q <= fetch_cnt_d;
         addr_q      <= addr_d;
         shadow_q    <= shadow_d;
         pixels_q    <= pixels_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign ram_addr   = addr_q;
   assign busy       = (state_q == FETCH);
   assign ram_clk_en = busy;
   assign pixels     = pixels_q;
   assign valid      = valid_q;
   assign overrun    = overrun_q;

endmodule
